// File: rtl/speech256_disp_pkg.sv
// Shared types and helpers for the Speech256 allophone display controller.
package speech256_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int ALLO_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_HOLD   = 2'd2
    } disp_state_e;

    // Digits 0/1 show the current code, digits 2/3 show the secondary byte
    // (previous code, or capture count when that option is built in).
    function automatic logic [3:0] nibble_sel(input logic [1:0]        d,
                                              input logic [ALLO_W-1:0] cur,
                                              input logic [7:0]        sec);
        logic [3:0] nib;
        case (d)
            2'd0:    nib = cur[3:0];
            2'd1:    nib = {2'b00, cur[5:4]};
            2'd2:    nib = sec[3:0];
            default: nib = sec[7:4];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Dwell timer: loads a start value, counts down to zero when enabled, flags zero.
module disp_hold_timer #(
    parameter int HOLD_W = 22
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (load) begin
            hold_cnt_d = load_val;
        end else if (dec && (hold_cnt_q != '0)) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign zero = (hold_cnt_q == '0);

endmodule

// File: rtl/allophone_display_ctrl.sv
// Captures Speech256 allophone codes and refreshes four 7-segment digit latches.
// Optional build macro ALLO_COUNT_EN: digits 2/3 show an 8-bit capture count.
module allophone_display_ctrl
    import speech256_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 2500000,
    parameter int HOLD_W      = 22
) (
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic [ALLO_W-1:0]     allo_in,
    input  logic                  allo_strobe,
    input  logic                  clear_in,
    output logic [3:0]            hexdigit_out,
    output logic [NUM_DIGITS-1:0] latch_out,
    output logic                  overrun
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    disp_state_e           state_q, state_d;
    logic [1:0]            d_q, d_d;
    logic [ALLO_W-1:0]     cur_q, cur_d;
    logic [ALLO_W-1:0]     pend_code_q, pend_code_d;
    logic                  pending_q, pending_d;
    logic                  refresh_req_q, refresh_req_d;
    logic                  overrun_q, overrun_d;
    logic [3:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] latch_q, latch_d;
    // Pass snapshot so a clear mid-pass cannot alter the digits still to come.
    logic [ALLO_W-1:0]     shadow_cur_q, shadow_cur_d;
    logic [7:0]            shadow_sec_q, shadow_sec_d;
    logic [7:0]            sec_now;
`ifdef ALLO_COUNT_EN
    logic [7:0]            alloc_cnt_q, alloc_cnt_d;
`else
    logic [ALLO_W-1:0]     prev_q, prev_d;
`endif

    logic take;
    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    disp_hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst_an   (rst_an),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d       = state_q;
        d_d           = d_q;
        cur_d         = cur_q;
        pend_code_d   = pend_code_q;
        pending_d     = pending_q;
        refresh_req_d = refresh_req_q;
        overrun_d     = overrun_q;
        hex_d         = hex_q;
        latch_d       = '0;
        shadow_cur_d  = shadow_cur_q;
        shadow_sec_d  = shadow_sec_q;
        sec_now       = '0;
        take          = 1'b0;
        timer_load    = 1'b0;
        timer_dec     = 1'b0;
`ifdef ALLO_COUNT_EN
        alloc_cnt_d   = alloc_cnt_q;
`else
        prev_d        = prev_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pending_q || refresh_req_q) begin
                    take          = 1'b1;
                    state_d       = ST_UPDATE;
                    d_d           = 2'd0;
                    refresh_req_d = 1'b0;
                    if (pending_q) begin
`ifndef ALLO_COUNT_EN
                        prev_d    = cur_q;
`endif
                        cur_d     = pend_code_q;
                        pending_d = 1'b0;
                    end
                end
            end
            ST_UPDATE: begin
                if (d_q == 2'd3) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_HOLD;
                        timer_load = 1'b1;
                    end
                end else begin
                    d_d     = d_q + 2'd1;
                    latch_d = NUM_DIGITS'(1) << d_d;
                    hex_d   = nibble_sel(d_d, shadow_cur_q, shadow_sec_q);
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A strobe coinciding with the IDLE hand-off is a fresh code, not an overrun.
        if (allo_strobe) begin
            pend_code_d = allo_in;
            pending_d   = 1'b1;
            if (pending_q && !(take && pending_q)) begin
                overrun_d = 1'b1;
            end
`ifdef ALLO_COUNT_EN
            alloc_cnt_d = alloc_cnt_q + 8'd1;
`endif
        end

        if (clear_in) begin
            cur_d         = '0;
            pending_d     = 1'b0;
            overrun_d     = 1'b0;
            refresh_req_d = 1'b1;
`ifdef ALLO_COUNT_EN
            alloc_cnt_d   = '0;
`else
            prev_d        = '0;
`endif
        end

`ifdef ALLO_COUNT_EN
        sec_now = alloc_cnt_d;
`else
        sec_now = {2'b00, prev_d};
`endif

        if (take) begin
            shadow_cur_d = cur_d;
            shadow_sec_d = sec_now;
            latch_d      = NUM_DIGITS'(1);
            hex_d        = nibble_sel(2'd0, cur_d, sec_now);
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q       <= ST_IDLE;
            d_q           <= 2'd0;
            cur_q         <= '0;
            pend_code_q   <= '0;
            pending_q     <= 1'b0;
            refresh_req_q <= 1'b1;
            overrun_q     <= 1'b0;
            hex_q         <= '0;
            latch_q       <= '0;
            shadow_cur_q  <= '0;
            shadow_sec_q  <= '0;
`ifdef ALLO_COUNT_EN
            alloc_cnt_q   <= '0;
`else
            prev_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            d_q           <= d_d;
            cur_q         <= cur_d;
            pend_code_q   <= pend_code_d;
            pending_q     <= pending_d;
            refresh_req_q <= refresh_req_d;
            overrun_q     <= overrun_d;
            hex_q         <= hex_d;
            latch_q       <= latch_d;
            shadow_cur_q  <= shadow_cur_d;
            shadow_sec_q  <= shadow_sec_d;
`ifdef ALLO_COUNT_EN
            alloc_cnt_q   <= alloc_cnt_d;
`else
            prev_q        <= prev_d;
`endif
        end
    end

    assign hexdigit_out = hex_q;
    assign latch_out    = latch_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_allophone_display_ctrl.sv
// Scoreboard bench for allophone_display_ctrl with a 4-cycle dwell.
module tb_allophone_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_an = 1'b0;
    logic [5:0] allo_in = '0;
    logic       allo_strobe = 1'b0;
    logic       clear_in = 1'b0;
    logic [3:0] hexdigit_out;
    logic [3:0] latch_out;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         ignore_mon = 1'b0;
    logic [7:0] m_cnt = '0;

    allophone_display_ctrl #(
        .HOLD_CYCLES (4),
        .HOLD_W      (3)
    ) dut (
        .clk          (clk),
        .rst_an       (rst_an),
        .allo_in      (allo_in),
        .allo_strobe  (allo_strobe),
        .clear_in     (clear_in),
        .hexdigit_out (hexdigit_out),
        .latch_out    (latch_out),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sec_of(input logic [5:0] prev);
`ifdef ALLO_COUNT_EN
        return m_cnt;
`else
        return {2'b00, prev};
`endif
    endfunction

    task automatic push_pass(input logic [5:0] c, input logic [5:0] p);
        logic [7:0] s;
        s = sec_of(p);
        exp_q.push_back({4'b0001, c[3:0]});
        exp_q.push_back({4'b0010, 2'b00, c[5:4]});
        exp_q.push_back({4'b0100, s[3:0]});
        exp_q.push_back({4'b1000, s[7:4]});
    endtask

    // Caller sits just after a rising edge; strobe is sampled on the next edge.
    task automatic drive_strobe(input logic [5:0] code);
        allo_in     = code;
        allo_strobe = 1'b1;
        @(posedge clk);
        #1;
        allo_strobe = 1'b0;
        m_cnt       = m_cnt + 8'd1;
    endtask

    task automatic wait_latch(input string name, input logic [3:0] val);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (latch_out == val) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for latch_out=%b, got %b", name, val, latch_out);
    endtask

    // From the last-digit cycle: four dwell cycles, then land in IDLE.
    task automatic to_idle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_an && !ignore_mon && (latch_out != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_latch: got latch=%b hex=%h expected no update", latch_out, hexdigit_out);
            end else begin
                check("digit", {latch_out, hexdigit_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_latch", {4'b0, latch_out}, 8'h00);
        check("rst_hex", {4'b0, hexdigit_out}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);

        // Post-reset refresh shows 0000, followed by a quiet dwell.
        push_pass(6'h00, 6'h00);
        #10 rst_an = 1'b1;
        wait_latch("pass_reset", 4'b1000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("hold_quiet", {4'b0, latch_out}, 8'h00);
        end
        @(posedge clk);
        #1;

        // Capture latency and first real code.
        drive_strobe(6'h2B);
        push_pass(6'h2B, 6'h00);
        check("lat_decide", {4'b0, latch_out}, 8'h00);
        @(posedge clk);
        #1;
        check("lat_first", {4'b0, latch_out}, 8'h01);
        wait_latch("pass_2b", 4'b1000);
        to_idle();

        drive_strobe(6'h15);
        push_pass(6'h15, 6'h2B);
        wait_latch("pass_15", 4'b1000);

        // Two strobes during the dwell: 01 is overwritten by 3F.
        @(posedge clk);
        #1;
        drive_strobe(6'h01);
        drive_strobe(6'h3F);
        check("overrun_set", {7'b0, overrun}, 8'h01);
        push_pass(6'h3F, 6'h15);
        wait_latch("pass_3f", 4'b1000);
        to_idle();
        check("overrun_sticky", {7'b0, overrun}, 8'h01);

        // Clear mid-pass: this pass finishes unchanged, the next shows zeros.
        drive_strobe(6'h2A);
        push_pass(6'h2A, 6'h3F);
        wait_latch("pass_2a_d1", 4'b0010);
        #1 clear_in = 1'b1;
        @(posedge clk);
        #1 clear_in = 1'b0;
        m_cnt = '0;
        check("overrun_clr", {7'b0, overrun}, 8'h00);
        push_pass(6'h00, 6'h00);
        wait_latch("pass_2a", 4'b1000);
        wait_latch("pass_clr", 4'b1000);
        to_idle();

        // Strobe coinciding with the IDLE hand-off.
        drive_strobe(6'h11);
        drive_strobe(6'h22);
        push_pass(6'h11, 6'h00);
        push_pass(6'h22, 6'h11);
        check("no_overrun_handoff", {7'b0, overrun}, 8'h00);
        wait_latch("pass_11", 4'b1000);
        wait_latch("pass_22", 4'b1000);
        to_idle();

        // Asynchronous reset in the middle of a pass.
        drive_strobe(6'h07);
        exp_q.push_back({4'b0001, 4'h7});
        exp_q.push_back({4'b0010, 4'h0});
        wait_latch("pass_07_d1", 4'b0010);
        #1 rst_an = 1'b0;
        #1;
        check("reset_instant_latch", {4'b0, latch_out}, 8'h00);
        check("reset_instant_hex", {4'b0, hexdigit_out}, 8'h00);
        m_cnt = '0;
        push_pass(6'h00, 6'h00);
        #5 rst_an = 1'b1;
        wait_latch("pass_after_reset", 4'b1000);
        to_idle();

`ifdef ALLO_COUNT_EN
        ignore_mon = 1'b1;
        repeat (16) drive_strobe(6'h05);
        repeat (40) @(posedge clk);
        #1;
        ignore_mon = 1'b0;
        drive_strobe(6'h21);
        push_pass(6'h21, 6'h00);
        check("cnt_17", m_cnt, 8'h11);
        wait_latch("pass_cnt17", 4'b1000);
        to_idle();

        ignore_mon = 1'b1;
        repeat (255) drive_strobe(6'h05);
        repeat (40) @(posedge clk);
        #1;
        ignore_mon = 1'b0;
        drive_strobe(6'h21);
        push_pass(6'h21, 6'h00);
        wait_latch("pass_cnt_wrap", 4'b1000);
        to_idle();
`endif

        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
